// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// TXDATA (BASE+0) pushes a byte on the first cycle of a store; STATUS (BASE+4)
// reports FIFO/FSM state and clears the sticky overflow flag when written.
// Bus side: a store is a level strobe with no ready; the peripheral never
// stalls the CPU, so a push into a full FIFO (without a same-cycle pop) is
// dropped and flagged. Reads have one cycle of latency through mem_rdata.
module uart_tx_io #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'hffff_ff20
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          we_hit_d;
  logic          overflow;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [3:0]    cnt4;
  logic [31:0]   status;

  logic in_win, we_hit, push_req, push_ok, pop, ovf_clr, baud_tick, fifo_full;
  logic unused_bits;

  assign in_win    = (mem_addr[31:3] == BASE_ADDR[31:3]);
  assign we_hit    = mem_we & in_win & ~mem_addr[2];
  assign push_req  = we_hit & ~we_hit_d;
  assign pop       = (state == IDLE) && (count != '0);
  assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
  // A same-cycle pop frees the slot the push lands in, so a full FIFO still accepts.
  assign push_ok   = push_req && (!fifo_full || pop);
  assign ovf_clr   = mem_we & in_win & mem_addr[2] & mem_wdata[3];
  assign baud_tick = (baud_cnt == 16'(CLK_DIV - 1));
  assign tx_busy   = (state != IDLE) || (count != '0);
  assign unused_bits = ^{mem_wdata[31:8], mem_addr[1:0]};

  // STATUS word assembled from live FIFO and FSM state.
  always_comb begin
    cnt4   = 4'(count);
    status = {20'd0, cnt4, 4'd0, overflow, (state != IDLE), fifo_full, (count == '0)};
  end

  // Next-state logic: IDLE waits for data, each serial phase ends on a baud terminal count.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0) state_next = START;
      START:   if (baud_tick) state_next = DATA;
      DATA:    if (baud_tick && bit_idx == 3'd7) state_next = STOP;
      STOP:    if (baud_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_next;
  end

  // Baud counter, shift register and registered serial output.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      if (state == IDLE || state_next != state || baud_tick) baud_cnt <= '0;
      else                                                   baud_cnt <= baud_cnt + 16'd1;
      if (pop) begin
        shreg <= fifo_mem[rd_ptr];
      end else if (state == DATA && baud_tick) begin
        shreg <= {1'b0, shreg[7:1]};
      end
      if (state != DATA)  bit_idx <= '0;
      else if (baud_tick) bit_idx <= bit_idx + 3'd1;
      case (state)
        START:   uart_tx <= 1'b0;
        DATA:    uart_tx <= shreg[0];
        default: uart_tx <= 1'b1;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Store edge detect, sticky overflow and the registered read port.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      we_hit_d  <= 1'b0;
      overflow  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      we_hit_d <= we_hit;
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (ovf_clr)         overflow <= 1'b0;
      if (!mem_we && in_win) mem_rdata <= mem_addr[2] ? status : 32'd0;
    end
  end

endmodule

// File: tb/tb_uart_tx_io.sv
// tb_uart_tx_io: randomized and directed bench for uart_tx_io with a
// cycle-level reference model, an expected-byte queue and a line monitor.
module tb_uart_tx_io;

  localparam int          C     = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hffff_ff20;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_rdata;
  logic        uart_tx;
  logic        tx_busy;

  uart_tx_io #(.CLK_DIV(C), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .sys_rst(sys_rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .uart_tx(uart_tx), .tx_busy(tx_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 25) $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Bytes accepted, in order; the monitor pops one per observed frame.
  logic [7:0]  exp_q[$];
  int          cyc = 0;
  int          m_cnt = 0;
  bit          m_ovf = 0, m_hit_d = 0, m_popped = 0, m_txbusy = 0;
  int          m_last_pop = 0, m_free = 0;
  logic [31:0] m_rdata = '0;

  // The transmitter takes a byte whenever data is waiting and the previous
  // frame (10 bit times) plus one idle cycle has elapsed since its pop.
  always @(posedge clk) begin : model
    int n;
    bit in_win, hit, push, pop, fbusy;
    logic [31:0] status;
    cyc++;
    n = cyc;
    if (sys_rst) begin
      m_cnt = 0; m_ovf = 0; m_hit_d = 0; m_popped = 0; m_free = 0;
      m_rdata = '0; m_txbusy = 0;
      exp_q.delete();
    end else begin
      in_win = (mem_addr[31:3] == BASE[31:3]);
      hit    = mem_we && in_win && !mem_addr[2];
      push   = hit && !m_hit_d;
      pop    = (m_cnt > 0) && (n >= m_free);
      fbusy  = m_popped && (n - 1 >= m_last_pop) && (n - 1 < m_last_pop + 10 * C);
      status = (32'(m_cnt) << 8) | {28'd0, m_ovf, fbusy, (m_cnt == DEPTH), (m_cnt == 0)};
      if (pop) begin
        m_popped = 1; m_last_pop = n; m_free = n + 10 * C + 1;
      end
      if (push) begin
        if (m_cnt < DEPTH || pop) begin
          exp_q.push_back(mem_wdata[7:0]);
          m_cnt++;
        end else begin
          m_ovf = 1;
        end
      end
      if (pop) m_cnt--;
      if (mem_we && in_win && mem_addr[2] && mem_wdata[3]) m_ovf = 0;
      if (!mem_we && in_win) m_rdata = mem_addr[2] ? status : 32'd0;
      m_hit_d  = hit;
      m_txbusy = (m_popped && n < m_last_pop + 10 * C) || (m_cnt > 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit mon_en = 0;
  bit mon_busy = 0;
  bit chk_en = 0;
  int fall_q[$];

  // Decode frames at bit centres and compare each byte against the queue head.
  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && uart_tx === 1'b0) begin
        mon_busy = 1;
        fall_q.push_back(cyc);
        repeat (C / 2) @(negedge clk);
        check("start_bit", 32'(uart_tx), 32'd0);
        for (int k = 0; k < 8; k++) begin
          repeat (C) @(negedge clk);
          b[k] = uart_tx;
        end
        repeat (C) @(negedge clk);
        check("stop_bit", 32'(uart_tx), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=%h required=no_frame", b);
        end else begin
          e = exp_q.pop_front();
          check("frame_byte", 32'(b), 32'(e));
        end
        mon_busy = 0;
      end
    end
  end

  // Every cycle: read port and busy flag must follow the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rdata", mem_rdata, m_rdata);
      check("tx_busy", 32'(tx_busy), 32'(m_txbusy));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int hold);
    @(negedge clk);
    mem_addr  = a;
    mem_wdata = d;
    mem_we    = 1'b1;
    repeat (hold) @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    mem_addr = a;
    mem_we   = 1'b0;
    @(negedge clk);
    v = mem_rdata;
    mem_addr = '0;
  endtask

  task automatic wait_drain(input int max);
    int k;
    k = 0;
    while ((tx_busy || exp_q.size() != 0 || mon_busy) && k < max) begin
      @(negedge clk);
      k++;
    end
    check("drain_within_budget", 32'(k < max), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [31:0] v;
    int op;
    bit low_seen;

    sys_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
    chk_en  = 1;
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    rd(BASE + 32'd4, v);
    check("rst_status", v, 32'h0000_0001);
    mon_en = 1;

    // Single byte: start bit appears two edges after the write edge.
    wr(BASE, 32'h0000_00A5, 1);
    check("idle_after_push", 32'(uart_tx), 32'd1);
    @(negedge clk);
    check("idle_during_pop", 32'(uart_tx), 32'd1);
    @(negedge clk);
    check("start_edge_latency", 32'(uart_tx), 32'd0);
    wait_drain(200);

    // Held strobe pushes exactly once.
    wr(BASE, 32'h0000_003C, 5);
    wait_drain(300);

    // Overflow: 10 pushes, first pops at once, 8 queue, 1 dropped.
    for (int i = 0; i < 10; i++) wr(BASE, 32'h40 + 32'(i), 1);
    rd(BASE + 32'd4, v);
    check("ovf_status", v, 32'h0000_080E);
    wr(BASE + 32'd4, 32'd8, 1);
    rd(BASE + 32'd4, v);
    check("ovf_cleared_bit3", 32'(v[3]), 32'd0);
    check("ovf_count_kept", 32'(v[11:8]), 32'd8);
    wait_drain(1000);

    // Back-to-back frames are 10*C+1 cycles apart.
    fall_q.delete();
    for (int i = 0; i < 3; i++) wr(BASE, $urandom, 1);
    wait_drain(500);
    check("b2b_frame_count", 32'(fall_q.size()), 32'd3);
    if (fall_q.size() >= 3) begin
      check("b2b_gap_0_1", 32'(fall_q[1] - fall_q[0]), 32'(10 * C + 1));
      check("b2b_gap_1_2", 32'(fall_q[2] - fall_q[1]), 32'(10 * C + 1));
    end

    // Randomized traffic: pushes, held strobes, out-of-window stores, status ops.
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      if (op < 6) begin
        wr(BASE, $urandom, $urandom_range(1, 4));
      end else if (op == 6) begin
        wr(BASE + 32'd8, $urandom, 1);
      end else if (op == 7) begin
        wr(BASE + 32'd4, 32'($urandom_range(0, 15)), 1);
      end else begin
        rd(BASE + 32'd4, v);
        rd(BASE, v);
        check("txdata_reads_zero", v, 32'd0);
      end
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end
    wait_drain(6000);

    // Reset during DATA bit 3 with more bytes queued behind it.
    mon_en = 0;
    wr(BASE, 32'h5A, 1);
    wr(BASE, 32'h11, 1);
    wr(BASE, 32'h22, 1);
    repeat (14) @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    check("midrst_uart_tx", 32'(uart_tx), 32'd1);
    check("midrst_tx_busy", 32'(tx_busy), 32'd0);
    rd(BASE + 32'd4, v);
    check("midrst_status", v, 32'h0000_0001);
    mon_en   = 1;
    low_seen = 0;
    repeat (120) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) low_seen = 1;
    end
    check("midrst_no_residual_frame", 32'(low_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the run must never hang.
  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
